// File: rtl/jack_frost_pkg.sv
// Shared types and default constants for the jump controller.
// Holds the FSM state encoding, coordinate width and default physics constants.
package jack_frost_pkg;

  localparam int COORD_W = 9;
  localparam int CALC_W  = 11;

  localparam logic signed [COORD_W-1:0] DEF_JUMP_V = 9'sd40;
  localparam logic        [COORD_W-1:0] DEF_G      = 9'd14;
  localparam logic signed [COORD_W-1:0] DEF_V_TERM = 9'sd64;

  typedef logic        [COORD_W-1:0] coord_t;
  typedef logic signed [COORD_W-1:0] vel_t;
  typedef logic signed [CALC_W-1:0]  calc_t;

  typedef enum logic {
    ST_GROUND = 1'b0,
    ST_AIR    = 1'b1
  } state_e;

  // Widen a height (unsigned) or a velocity (signed) to the arithmetic width.
  function automatic calc_t ext_u(coord_t a);
    return calc_t'({2'b00, a});
  endfunction

  function automatic calc_t ext_s(vel_t a);
    return calc_t'({{2{a[COORD_W-1]}}, a});
  endfunction

endpackage

// File: rtl/jump_ctrl_if.sv
// Frame/button/floor inputs and position/velocity/status outputs of jump_ctrl.
interface jump_ctrl_if;
  import jack_frost_pkg::*;

  logic   frame_tick;
  logic   jump_btn;
  coord_t ground_y;
  coord_t y;
  vel_t   v;
  logic   air;
  logic   landed;

  modport master (
    output frame_tick, jump_btn, ground_y,
    input  y, v, air, landed
  );

  modport slave (
    input  frame_tick, jump_btn, ground_y,
    output y, v, air, landed
  );

endinterface

// File: rtl/jump_ctrl_edge_rise.sv
// Rising-edge detector: one-cycle pulse when d goes from 0 to 1.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb d_d = d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d_d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/jump_ctrl.sv
// Per-frame jump/fall physics for a platformer player (GROUND/AIR FSM).
// Optional feature: define JUMP_CTRL_DOUBLE_JUMP_EN for one extra mid-air jump.
module jump_ctrl
  import jack_frost_pkg::*;
#(
  parameter vel_t   JUMP_V = DEF_JUMP_V,
  parameter coord_t G      = DEF_G,
  parameter vel_t   V_TERM = DEF_V_TERM
) (
  input  logic         clk,
  input  logic         rst_n,
  jump_ctrl_if.slave   bus
);

  localparam calc_t JUMP_EXT  = calc_t'({{2{JUMP_V[COORD_W-1]}}, JUMP_V});
  localparam calc_t G_EXT     = calc_t'({2'b00, G});
  localparam calc_t HALF_G    = calc_t'({3'b000, G[COORD_W-1:1]});
  localparam calc_t NEG_VTERM = -calc_t'({{2{V_TERM[COORD_W-1]}}, V_TERM});
  localparam calc_t Y_MAX     = calc_t'(11'sd511);
  localparam calc_t LAUNCH_V  = JUMP_EXT - G_EXT;

  state_e state_q, state_d;
  coord_t y_q, y_d;
  vel_t   v_q, v_d;
  logic   landed_q, landed_d;
  logic   jump_req_q, jump_req_d;
  logic   rise;
  logic   req;
  logic   dj_take;
  calc_t  y_ext, v_ext, gy_ext;
  calc_t  launch_y, fall_y, fall_v;

  edge_rise u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.jump_btn),
    .rise  (rise)
  );

  // An edge arriving on the tick cycle itself counts for that tick.
  assign req = jump_req_q | rise;

`ifdef JUMP_CTRL_DOUBLE_JUMP_EN
  logic spare_q, spare_d;

  assign dj_take = req & spare_q;

  always_comb begin
    spare_d = spare_q;
    if (state_q == ST_GROUND)                            spare_d = 1'b1;
    else if (bus.frame_tick && dj_take)                  spare_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spare_q <= 1'b1;
    else        spare_q <= spare_d;
  end
`else
  assign dj_take = 1'b0;
`endif

  always_comb begin
    y_ext    = ext_u(y_q);
    v_ext    = ext_s(v_q);
    gy_ext   = ext_u(bus.ground_y);
    launch_y = y_ext + JUMP_EXT - HALF_G;
    fall_y   = y_ext + v_ext - HALF_G;
    fall_v   = v_ext - G_EXT;
    if (fall_v < NEG_VTERM) fall_v = NEG_VTERM;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    v_d        = v_q;
    landed_d   = 1'b0;
    jump_req_d = req;

    if (bus.frame_tick) begin
      jump_req_d = 1'b0;
      unique case (state_q)
        ST_GROUND: begin
          if (req) begin
            y_d     = launch_y[COORD_W-1:0];
            v_d     = LAUNCH_V[COORD_W-1:0];
            state_d = ST_AIR;
          end else if (bus.ground_y < y_q) begin
            v_d     = '0;
            state_d = ST_AIR;
          end else begin
            y_d = bus.ground_y;
            v_d = '0;
          end
        end
        ST_AIR: begin
          if (dj_take) begin
            y_d = launch_y[COORD_W-1:0];
            v_d = LAUNCH_V[COORD_W-1:0];
          end else if (fall_y <= gy_ext) begin
            y_d      = bus.ground_y;
            v_d      = '0;
            state_d  = ST_GROUND;
            landed_d = 1'b1;
          end else if (fall_y > Y_MAX) begin
            y_d = Y_MAX[COORD_W-1:0];
            v_d = '0;
          end else begin
            y_d = fall_y[COORD_W-1:0];
            v_d = fall_v[COORD_W-1:0];
          end
        end
        default: state_d = ST_GROUND;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_GROUND;
      y_q        <= '0;
      v_q        <= '0;
      landed_q   <= 1'b0;
      jump_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      v_q        <= v_d;
      landed_q   <= landed_d;
      jump_req_q <= jump_req_d;
    end
  end

  assign bus.y      = y_q;
  assign bus.v      = v_q;
  assign bus.air    = (state_q == ST_AIR);
  assign bus.landed = landed_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed and randomized bench for jump_ctrl, checked against an integer physics model.
module tb_jump_ctrl;

`ifdef JUMP_CTRL_DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif

  localparam int JV = 40;
  localparam int GV = 14;
  localparam int HG = GV / 2;
  localparam int VT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  jump_ctrl_if bus ();

  jump_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural model state
  int m_y, m_v;
  bit m_air, m_landed, m_req, m_prev, m_spare;

  task automatic model_reset();
    m_y = 0; m_v = 0; m_air = 0; m_landed = 0;
    m_req = 0; m_prev = 0; m_spare = 1;
  endtask

  task automatic model_step(input bit tick, input bit btn, input int gy);
    bit rise, req;
    int yn, vn;
    rise = btn && !m_prev;
    m_prev = btn;
    req = m_req || rise;
    m_landed = 0;
    if (!tick) begin
      m_req = req;
      return;
    end
    m_req = 0;
    if (!m_air) begin
      if (req) begin
        m_y = (m_y + JV - HG) % 512; m_v = JV - GV; m_air = 1;
      end else if (gy < m_y) begin
        m_v = 0; m_air = 1;
      end else begin
        m_y = gy; m_v = 0;
      end
    end else if (DJ && req && m_spare) begin
      m_y = (m_y + JV - HG) % 512; m_v = JV - GV; m_spare = 0;
    end else begin
      yn = m_y + m_v - HG;
      vn = m_v - GV;
      if (vn < -VT) vn = -VT;
      if (yn <= gy) begin
        m_y = gy; m_v = 0; m_air = 0; m_landed = 1; m_spare = 1;
      end else if (yn > 511) begin
        m_y = 511; m_v = 0;
      end else begin
        m_y = yn; m_v = vn;
      end
    end
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".y"},      bus.y,          m_y);
    chk({tag, ".v"},      $signed(bus.v), m_v);
    chk({tag, ".air"},    bus.air,        m_air);
    chk({tag, ".landed"}, bus.landed,     m_landed);
  endtask

  task automatic cyc(input bit tick, input bit btn, input int gy, input string tag);
    @(negedge clk);
    bus.frame_tick = tick;
    bus.jump_btn   = btn;
    bus.ground_y   = gy[8:0];
    @(posedge clk);
    model_step(tick, btn, gy);
    #1;
    check_model(tag);
  endtask

  task automatic frame(input bit btn, input int gy, input string tag);
    cyc(1'b0, btn, gy, tag);
    cyc(1'b0, btn, gy, tag);
    cyc(1'b1, btn, gy, tag);
  endtask

  task automatic expect_yv(input string tag, input int ey, input int ev);
    chk({tag, ".y"}, bus.y, ey);
    chk({tag, ".v"}, $signed(bus.v), ev);
  endtask

  initial begin
    int exp_y[6] = '{33, 52, 57, 48, 25, 0};
    int exp_v[6] = '{26, 12, -2, -16, -30, 0};
    int prev_y, prev_v, guard;
    bit btn_r;
    int gy_r;

    // Reset state
    bus.frame_tick = 1'b0;
    bus.jump_btn   = 1'b0;
    bus.ground_y   = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.y", bus.y, 0);
    chk("reset.v", $signed(bus.v), 0);
    chk("reset.air", bus.air, 0);
    chk("reset.landed", bus.landed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // First tick after release settles to the floor
    frame(1'b0, 0, "first_tick");
    chk("first_tick.air", bus.air, 0);

    // Basic jump arc, then button held across ground ticks
    for (int k = 0; k < 6; k++) begin
      frame(1'b1, 0, "arc");
      expect_yv($sformatf("arc%0d", k + 1), exp_y[k], exp_v[k]);
    end
    chk("arc6.landed", bus.landed, 1);
    chk("arc6.air", bus.air, 0);
    cyc(1'b0, 1'b1, 0, "after_land");
    chk("after_land.landed", bus.landed, 0);
    for (int k = 0; k < 10; k++) begin
      frame(1'b1, 0, "hold");
      chk("hold.air", bus.air, 0);
    end
    frame(1'b0, 0, "release");

    // Second and third press mid-air
    frame(1'b1, 0, "dj1");
    expect_yv("dj1", 33, 26);
    frame(1'b0, 0, "dj2");
    expect_yv("dj2", 52, 12);
    frame(1'b1, 0, "dj3");
    if (DJ) expect_yv("dj3", 85, 26);
    else    expect_yv("dj3", 57, -2);
    frame(1'b0, 0, "dj4");
    if (DJ) expect_yv("dj4", 104, 12);
    else    expect_yv("dj4", 48, -16);
    frame(1'b1, 0, "dj5");
    if (DJ) expect_yv("dj5", 109, -2);
    else    expect_yv("dj5", 25, -30);
    guard = 0;
    while (m_air && guard < 30) begin
      frame(1'b0, 0, "dj_fall");
      guard++;
    end
    chk("dj_fall.grounded", bus.air, 0);

    // Ledge walk-off
    frame(1'b0, 100, "ledge0");
    expect_yv("ledge0", 100, 0);
    frame(1'b0, 0, "ledge1");
    chk("ledge1.v", $signed(bus.v), 0);
    chk("ledge1.air", bus.air, 1);
    frame(1'b0, 0, "ledge2");
    expect_yv("ledge2", 93, -14);
    guard = 0;
    while (m_air && guard < 30) begin
      frame(1'b0, 0, "ledge_fall");
      guard++;
    end
    chk("ledge_fall.grounded", bus.air, 0);

    // Terminal velocity from the ceiling
    frame(1'b0, 511, "term_top");
    expect_yv("term_top", 511, 0);
    frame(1'b0, 0, "term_ledge");
    guard = 0;
    while (m_air && guard < 30) begin
      prev_y = bus.y;
      prev_v = $signed(bus.v);
      frame(1'b0, 0, "term_fall");
      chk("term.v_floor", ($signed(bus.v) >= -64), 1);
      if (bus.air && prev_v == -64) chk("term.dy", int'(bus.y) - prev_y, -71);
      guard++;
    end
    chk("term.grounded", bus.air, 0);

    // Reset mid-air aborts the jump
    frame(1'b1, 0, "rst_j1");
    frame(1'b1, 0, "rst_j2");
    frame(1'b1, 0, "rst_j3");
    expect_yv("rst_j3", 57, -2);
    @(negedge clk);
    bus.jump_btn = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.y", bus.y, 0);
    chk("midrst.v", $signed(bus.v), 0);
    chk("midrst.air", bus.air, 0);
    chk("midrst.landed", bus.landed, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) frame(1'b0, 0, "post_rst");

    // Randomized traffic
    btn_r = 1'b0;
    gy_r  = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) btn_r = ~btn_r;
      if ($urandom_range(0, 19) == 0) gy_r = $urandom_range(0, 300);
      cyc(($urandom_range(0, 2) == 0), btn_r, gy_r, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jump_ctrl.md
JUMP_CTRL -- requirements
Module: jump_ctrl

Interface
REQ-001 Parameter JUMP_V, default 9'sd40, SHALL set the launch velocity (signed, upward positive).
REQ-002 Parameter G, default 9'd14, SHALL set the per-frame velocity decrement; half-gravity SHALL be G/2 (truncated, 7 at the default).
REQ-003 Parameter V_TERM, default 9'sd64, SHALL set the magnitude of the terminal fall velocity.
REQ-004 Port: clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port: frame_tick  input  1  one-cycle pulse, once per game frame.
REQ-007 Port: jump_btn  input  1  jump key level, already synchronised to clk.
REQ-008 Port: ground_y  input  9  unsigned floor height under the player.
REQ-009 Port: y  output  9  unsigned player height (upward positive), registered.
REQ-010 Port: v  output  9  signed two's-complement vertical velocity, registered.
REQ-011 Port: air  output  1  high in state AIR.
REQ-012 Port: landed  output  1  one-cycle pulse on touchdown.

Function
REQ-013 The FSM SHALL have two states: GROUND and AIR.
REQ-014 A rising edge of jump_btn SHALL set a jump_req latch; the latch SHALL clear when consumed, and on any frame_tick in AIR when it is not consumed.
REQ-015 A rising edge in the same cycle as frame_tick SHALL count as a request for that tick.
REQ-016 All y/v updates SHALL occur only on cycles with frame_tick=1, visible on the next cycle (latency 1); y, v and air SHALL hold between ticks.
REQ-017 GROUND with jump_req on a tick: y <= y + JUMP_V - G/2; v <= JUMP_V - G; state -> AIR.
REQ-018 GROUND without jump_req on a tick, with ground_y < y (ledge): v <= 0; state -> AIR; y unchanged.
REQ-019 GROUND without jump_req, with ground_y >= y: y <= ground_y; v <= 0.
REQ-020 AIR on a tick: y_next = y + v - G/2 and v_next = v - G, both evaluated at 11-bit signed width.
REQ-021 v_next SHALL clamp to -V_TERM when it is below -V_TERM.
REQ-022 AIR, if y_next <= ground_y: y <= ground_y; v <= 0; state -> GROUND; landed=1 for exactly that cycle.
REQ-023 AIR, if y_next > 511: y <= 511; v <= 0 (ceiling bump); remain in AIR.
REQ-024 AIR otherwise: y <= y_next; v <= v_next.
REQ-025 landed SHALL be 0 in every cycle other than the one defined in REQ-022.

Reset
REQ-026 While rst_n=0: state=GROUND, y=0, v=0, air=0, landed=0, jump_req=0, button-edge register=0.
REQ-027 Reset asserted mid-air SHALL abort the jump immediately, with no landed pulse.
REQ-028 The first tick after reset release SHALL follow REQ-019.

Configuration
REQ-029 Macro JUMP_CTRL_DOUBLE_JUMP_EN defined: one extra jump per airborne period.
- AIR with jump_req on a tick and the spare-jump flag set: v <= JUMP_V - G; y <= y + JUMP_V - G/2; flag cleared.
- Flag set on entering GROUND and on reset.
REQ-030 Macro undefined: no flag logic is built, and jump_req is ignored in AIR.

Structure
REQ-031 jack_frost_pkg SHALL hold the state encoding, the default G/JUMP_V/V_TERM constants and the 9-bit coordinate width.
REQ-032 One sub-module, edge_rise (rising-edge detector), SHALL produce the jump_btn edge.

Verification
REQ-033 Jump, ground_y=0, y=0, press before tick 1 -> (y,v) per tick: (33,26), (52,12), (57,-2), (48,-16), (25,-30), then (0,0) with landed=1 on tick 6 and air=0.
REQ-034 Button held high across 10 ticks after landing -> no relaunch without a new rising edge.
REQ-035 Ledge: GROUND y=100, ground_y drops to 0 -> tick 1 v=0 air=1; tick 2 (93,-14); fall continues until landing.
REQ-036 Terminal velocity: fall from y=511, ground_y=0 -> v never below -64, and consecutive y deltas settle at -71.
REQ-037 rst_n pulsed low at tick 3 of a jump -> y=0, v=0, air=0 immediately, and no landed pulse.
REQ-038 With JUMP_CTRL_DOUBLE_JUMP_EN defined: second press at (52,12) -> (85,26), and a third press has no effect. With the macro undefined: the second press is ignored.
